// File: rtl/mem_write_checker_pkg.sv
// Shared state encodings and fail-reason codes for the memory store-stream checker.
package mem_write_checker_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PASS = 2'd2;
    localparam logic [1:0] FAIL = 2'd3;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISMATCH = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_OVERFLOW = 2'b11;

endpackage

// File: rtl/mwc_exp_table.sv
// Expected-store table: DEPTH entries of (address, data), one sync write port, one comb read port.
// Write takes effect on the next edge; the read port has no latency and no backpressure.
module mwc_exp_table #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   widx,
    input  logic [WIDTH-1:0]           waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0]   ridx,
    output logic [WIDTH-1:0]           raddr,
    output logic [WIDTH-1:0]           rdata
);

    // Deliberately unreset so a loaded table survives a checker reset.
    logic [WIDTH-1:0] addr_mem [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            addr_mem[widx] <= waddr;
            data_mem[widx] <= wdata;
        end
    end

    assign raddr = addr_mem[ridx];
    assign rdata = data_mem[ridx];

endmodule

// File: rtl/mem_write_checker.sv
// Checks an in-order stream of expected stores; MEM_WRITE_CHECKER_CAPTURE_EN adds bad_addr/bad_data.
// Latency: a store sampled at edge n is reflected in state and outputs after edge n.
// Backpressure: none; the checker only observes the store port.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] IGN_BASE  = WIDTH'(80),
    parameter logic [WIDTH-1:0] IGN_LIMIT = WIDTH'(83),
    parameter int               TIMEOUT   = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memwrite,
    input  logic [WIDTH-1:0]           dataadr,
    input  logic [WIDTH-1:0]           writedata,
    input  logic                       exp_we,
    input  logic [$clog2(DEPTH)-1:0]   exp_idx,
    input  logic [WIDTH-1:0]           exp_addr,
    input  logic [WIDTH-1:0]           exp_data,
    input  logic [$clog2(DEPTH):0]     exp_count,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [1:0]                 fail_code,
    output logic [$clog2(DEPTH):0]     match_cnt
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]           bad_addr,
    output logic [WIDTH-1:0]           bad_data
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam int MW = IW + 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // With the timeout disabled the cycle counter simply saturates at all-ones.
    localparam logic [CW-1:0] CMAX = (TIMEOUT != 0) ? CW'(TIMEOUT - 1) : {CW{1'b1}};

    logic [1:0]       state;
    logic [MW-1:0]    cnt_q;
    logic [CW-1:0]    cyc;
    logic [WIDTH-1:0] ent_addr;
    logic [WIDTH-1:0] ent_data;
    logic [MW-1:0]    match_nxt;
    logic             ign;
    logic             store;
    logic             hit;
    logic             to_hit;
    logic             cap_ld;

    mwc_exp_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_table (
        .clk   (clk),
        .we    (exp_we && (state != RUN)),
        .widx  (exp_idx),
        .waddr (exp_addr),
        .wdata (exp_data),
        .ridx  (match_cnt[IW-1:0]),
        .raddr (ent_addr),
        .rdata (ent_data)
    );

    always_comb begin
        ign       = (IGN_LIMIT >= IGN_BASE) && (dataadr >= IGN_BASE) && (dataadr <= IGN_LIMIT);
        store     = memwrite && !ign;
        hit       = (dataadr == ent_addr) && (writedata == ent_data);
        to_hit    = (TIMEOUT != 0) && (cyc == CMAX);
        match_nxt = match_cnt + MW'(1);
        cap_ld    = store && (((state == RUN) && !hit) || (state == PASS));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt_q     <= '0;
            cyc       <= '0;
            match_cnt <= '0;
            fail_code <= FC_NONE;
        end else if (start) begin
            cnt_q     <= exp_count;
            cyc       <= '0;
            match_cnt <= '0;
            fail_code <= FC_NONE;
            if (exp_count == '0) begin
                state <= PASS;
            end else if (exp_count > MW'(DEPTH)) begin
                state     <= FAIL;
                fail_code <= FC_OVERFLOW;
            end else begin
                state <= RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    if (cyc != CMAX) cyc <= cyc + CW'(1);
                    // A completing store beats a same-cycle timeout; a mismatch is reported over it.
                    if (store && hit) begin
                        match_cnt <= match_nxt;
                        if (match_nxt == cnt_q) begin
                            state <= PASS;
                        end else if (to_hit) begin
                            state     <= FAIL;
                            fail_code <= FC_TIMEOUT;
                        end
                    end else if (store) begin
                        state     <= FAIL;
                        fail_code <= FC_MISMATCH;
                    end else if (to_hit) begin
                        state     <= FAIL;
                        fail_code <= FC_TIMEOUT;
                    end
                end
                PASS: begin
                    if (store) begin
                        state     <= FAIL;
                        fail_code <= FC_OVERFLOW;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (!reset || start) begin
            bad_addr <= '0;
            bad_data <= '0;
        end else if (cap_ld) begin
            bad_addr <= dataadr;
            bad_data <= writedata;
        end
    end
`endif

    assign busy = (state == RUN);
    assign done = (state == PASS) || (state == FAIL);
    assign pass = (state == PASS);

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed self-checking bench for mem_write_checker (TIMEOUT=16, default table geometry).
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        exp_we;
    logic [2:0]  exp_idx;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_count;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [3:0]  match_cnt;
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
    logic [31:0] bad_addr;
    logic [31:0] bad_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_write_checker #(
        .WIDTH     (32),
        .DEPTH     (8),
        .IGN_BASE  (32'd80),
        .IGN_LIMIT (32'd83),
        .TIMEOUT   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .exp_we    (exp_we),
        .exp_idx   (exp_idx),
        .exp_addr  (exp_addr),
        .exp_data  (exp_data),
        .exp_count (exp_count),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_code (fail_code),
        .match_cnt (match_cnt)
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
        ,
        .bad_addr  (bad_addr),
        .bad_data  (bad_data)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
        exp_we   = 1'b1;
        exp_idx  = 3'(i);
        exp_addr = a;
        exp_data = d;
        step();
        exp_we   = 1'b0;
    endtask

    task automatic go(input int n);
        start     = 1'b1;
        exp_count = 4'(n);
        step();
        start     = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        step();
        memwrite  = 1'b0;
    endtask

    // Status vector {busy, done, pass, fail_code, match_cnt}.
    task automatic chk(input string tag, input logic bz, input logic dn, input logic ps,
                       input logic [1:0] fc, input logic [3:0] mc);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {busy, done, pass, fail_code, match_cnt};
        exp = {bz, dn, ps, fc, mc};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {busy,done,pass,fc,mc}=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cap(input string tag, input logic [31:0] a, input logic [31:0] d);
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
        checks++;
        assert ({bad_addr, bad_data} === {a, d}) else begin
            errors++;
            $error("FAIL %s: observed bad=(%0d,%0d) expected (%0d,%0d)", tag, bad_addr, bad_data, a, d);
        end
`else
        if (a === 32'hx || d === 32'hx) $display("%s: capture not built", tag);
`endif
    endtask

    initial begin
        reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0;
        exp_count = '0; start = 1'b0;
        idle(2);
        chk("reset", 0, 0, 0, 2'b00, 4'd0);
        chk_cap("reset_cap", 32'd0, 32'd0);
        reset = 1'b1;

        // Single expected store with an ignored scratch store first
        load(0, 32'd84, 32'd7);
        go(1);
        chk("t1_busy", 1, 0, 0, 2'b00, 4'd0);
        st(32'd80, 32'd3);
        chk("t1_ignored", 1, 0, 0, 2'b00, 4'd0);
        st(32'd84, 32'd7);
        chk("t1_pass", 0, 1, 1, 2'b00, 4'd1);
        st(32'd80, 32'd9);
        chk("pass_ignored", 0, 1, 1, 2'b00, 4'd1);
        st(32'd100, 32'd5);
        chk("extra_store", 0, 1, 0, 2'b11, 4'd1);
        chk_cap("extra_cap", 32'd100, 32'd5);

        // Mismatching store; start clears the previous fail code and capture
        go(1);
        chk("t2_busy", 1, 0, 0, 2'b00, 4'd0);
        chk_cap("start_clr_cap", 32'd0, 32'd0);
        st(32'd88, 32'd7);
        chk("mismatch", 0, 1, 0, 2'b01, 4'd0);
        chk_cap("mismatch_cap", 32'd88, 32'd7);

        // Timeout after two of three stores: fails on the 16th RUN cycle
        load(0, 32'd4, 32'd1);
        load(1, 32'd8, 32'd2);
        load(2, 32'd12, 32'd3);
        go(3);
        st(32'd4, 32'd1);
        st(32'd8, 32'd2);
        chk("t3_two", 1, 0, 0, 2'b00, 4'd2);
        idle(13);
        chk("t3_last_run", 1, 0, 0, 2'b00, 4'd2);
        idle(1);
        chk("timeout", 0, 1, 0, 2'b10, 4'd2);
        chk_cap("timeout_cap", 32'd0, 32'd0);

        // Reset mid-run with a store on the reset cycle, then rerun with preserved table
        go(3);
        st(32'd4, 32'd1);
        chk("rst_pre", 1, 0, 0, 2'b00, 4'd1);
        reset = 1'b0;
        st(32'd8, 32'd2);
        reset = 1'b1;
        chk("rst_mid", 0, 0, 0, 2'b00, 4'd0);
        go(3);
        st(32'd4, 32'd1);
        st(32'd8, 32'd2);
        st(32'd12, 32'd3);
        chk("rst_rerun_pass", 0, 1, 1, 2'b00, 4'd3);

        // Completing store on the timeout cycle wins
        go(1);
        idle(15);
        chk("to_pass_pre", 1, 0, 0, 2'b00, 4'd0);
        st(32'd4, 32'd1);
        chk("to_pass", 0, 1, 1, 2'b00, 4'd1);

        // Mismatch on the timeout cycle reports mismatch
        go(1);
        idle(15);
        st(32'd8, 32'd8);
        chk("to_mismatch", 0, 1, 0, 2'b01, 4'd0);

        // start during RUN clears match and cycle counters
        go(2);
        st(32'd4, 32'd1);
        idle(5);
        chk("restart_pre", 1, 0, 0, 2'b00, 4'd1);
        go(2);
        chk("restart", 1, 0, 0, 2'b00, 4'd0);
        idle(15);
        chk("restart_run", 1, 0, 0, 2'b00, 4'd0);
        idle(1);
        chk("restart_to", 0, 1, 0, 2'b10, 4'd0);

        // exp_count boundaries
        go(0);
        chk("count_zero", 0, 1, 1, 2'b00, 4'd0);
        go(9);
        chk("count_over", 0, 1, 0, 2'b11, 4'd0);
        go(8);
        chk("count_depth", 1, 0, 0, 2'b00, 4'd0);

        // Table writes during RUN are dropped
        go(1);
        load(0, 32'd20, 32'd20);
        st(32'd4, 32'd1);
        chk("we_in_run", 0, 1, 1, 2'b00, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised store-stream checker that sits beside the processor's data-memory port (`memwrite`, `dataadr`, `writedata`) and replaces hard-coded single-store pass/fail checks. It holds a loadable table of up to DEPTH expected (address, data) stores and checks that they occur in order. Stores inside a configurable ignore window, such as scratch stack traffic, are skipped. It reports pass or fail with a reason code and a cycle timeout, so the same block serves simulation benches and on-FPGA self-test.

## Interface
- WIDTH, 32, address/data width
- DEPTH, 8, max expected stores (power of two, ≥2)
- IGN_BASE, 32'd80, first ignored address (inclusive)
- IGN_LIMIT, 32'd83, last ignored address (inclusive); IGN_LIMIT < IGN_BASE disables the window
- TIMEOUT, 1024, cycles allowed in RUN; 0 disables the timeout
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- memwrite  in  1  store strobe from the processor
- dataadr  in  WIDTH  store address
- writedata  in  WIDTH  store data
- exp_we  in  1  table write strobe
- exp_idx  in  $clog2(DEPTH)  table entry index
- exp_addr  in  WIDTH  expected address
- exp_data  in  WIDTH  expected data
- exp_count  in  $clog2(DEPTH)+1  number of valid entries, sampled on start
- start  in  1  one-cycle pulse that arms the check
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- fail_code  out  2  00 none, 01 mismatch, 10 timeout, 11 overflow
- match_cnt  out  $clog2(DEPTH)+1  stores matched so far
- bad_addr, bad_data  out  WIDTH  offending store (present only with capture enabled)

## Operation
- States: IDLE, RUN, PASS, FAIL. On reset, enter IDLE with every output 0.
- exp_we writes the table when the state is not RUN; it is ignored in RUN. Table contents survive reset.
- start from any state:
  - Latches exp_count, clears match_cnt, the cycle counter, fail_code and the capture registers.
  - Enters RUN the next cycle.
  - If exp_count is 0, enters PASS directly.
  - If exp_count > DEPTH, enters FAIL with code 11.
- RUN, per cycle with memwrite=1:
  - If IGN_BASE ≤ dataadr ≤ IGN_LIMIT, the store is ignored.
  - Otherwise, if (dataadr, writedata) equals entry[match_cnt], match_cnt increments. When the new value equals the latched count, enter PASS.
  - Any other store enters FAIL with code 01.
- Any store that is not ignored while in PASS enters FAIL with code 11 (extra store).
- Cycle counter increments each RUN cycle. When it reaches TIMEOUT-1 without PASS, enter FAIL with code 10.
- Simultaneous events:
  - A completing store and a timeout in the same cycle resolve to PASS.
  - A mismatching store and a timeout in the same cycle resolve to fail_code 01.
  - start has priority over every other event.
- All comparisons are full-width equality. Counters saturate and never wrap.

## Timing
- One-cycle response: the store sampled at edge n is reflected in match_cnt, state and outputs after edge n.
- busy rises the cycle after start.
- PASS/FAIL are sticky until the next start or reset.
- reset=0 in any state, mid-run included, forces IDLE on the next edge. Any store in that cycle is discarded.

## Configuration
- MEM_WRITE_CHECKER_CAPTURE_EN defined:
  - bad_addr and bad_data exist.
  - They load the offending store on entry to FAIL with code 01 or 11.
  - They hold 0 for code 10 and after start or reset.
- Undefined: the ports and registers are absent, and all other behaviour is unchanged.

## Structure
- Package mem_write_checker_pkg holds the state enum (IDLE/RUN/PASS/FAIL) and the fail-code constants (FC_NONE, FC_MISMATCH, FC_TIMEOUT, FC_OVERFLOW).
- One sub-module, mwc_exp_table: DEPTH×(2·WIDTH) register file with one synchronous write port and one combinational read port indexed by match_cnt.

## Test plan
- Load entry0=(84,7), count=1, start. Stores (80,3) then (84,7) → pass=1, match_cnt=1, fail_code=00.
- Same load, store (88,7) → FAIL, fail_code=01; with capture enabled, bad_addr=88 and bad_data=7.
- count=3, entries (4,1),(8,2),(12,3); issue only the first two stores, TIMEOUT=16 → FAIL code 10 when the counter reaches 15; match_cnt=2.
- Reach PASS, then store (100,5) → FAIL code 11. Store (80,9) in PASS → stays PASS.
- Pull reset low for one cycle mid-RUN → IDLE, all outputs 0; a new start with the preserved table reaches PASS.
- Completing store on the timeout cycle → PASS. start pulsed during RUN → counters cleared, busy stays high.
